// File: rtl/pc_redirect_ctrl.sv
// Front-end redirect controller: arbitrates jump/branch/trap redirects into the PC
// select, holds them across hazard stalls and follows each applied one with a flush.
module pc_redirect_ctrl #(
    parameter int ADDR_SIZE    = 20,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hazard_stall_i,
    input  logic                 jal_valid_i,
    input  logic [ADDR_SIZE-1:0] jal_target_i,
    input  logic                 br_valid_i,
    input  logic                 br_taken_i,
    input  logic [ADDR_SIZE-1:0] br_target_i,
    input  logic                 trap_valid_i,
    input  logic [ADDR_SIZE-1:0] trap_vector_i,
    output logic [1:0]           sel_o,
    output logic                 pc_stall_o,
    output logic [ADDR_SIZE-1:0] tgt1_o,
    output logic [ADDR_SIZE-1:0] tgt2_o,
    output logic [ADDR_SIZE-1:0] tgt3_o,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic [15:0]          redirect_cnt_o
);
    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t               state, state_nxt;
    logic [1:0]           pend_sel, pend_sel_nxt;
    logic [ADDR_SIZE-1:0] pend_tgt, pend_tgt_nxt;
    logic [3:0]           fcnt, fcnt_nxt;
    logic [1:0]           req_sel;
    logic [ADDR_SIZE-1:0] req_tgt;

    // Select encoding doubles as priority: trap (3) > branch (2) > jump (1).
    always_comb begin
        req_sel = 2'd0;
        req_tgt = '0;
        if (trap_valid_i) begin
            req_sel = 2'd3;
            req_tgt = trap_vector_i;
        end else if (br_valid_i && br_taken_i) begin
            req_sel = 2'd2;
            req_tgt = br_target_i;
        end else if (jal_valid_i) begin
            req_sel = 2'd1;
            req_tgt = jal_target_i;
        end
    end

    always_comb begin
        state_nxt    = state;
        pend_sel_nxt = pend_sel;
        pend_tgt_nxt = pend_tgt;
        fcnt_nxt     = fcnt;
        sel_o        = 2'd0;
        case (state)
            IDLE: begin
                if (req_sel != 2'd0) begin
                    if (!hazard_stall_i) begin
                        sel_o     = req_sel;
                        state_nxt = FLUSH;
                        fcnt_nxt  = FLUSH_LOAD;
                    end else begin
                        pend_sel_nxt = req_sel;
                        pend_tgt_nxt = req_tgt;
                        state_nxt    = PEND;
                    end
                end
            end
            PEND: begin
                if (hazard_stall_i) begin
                    if (req_sel > pend_sel) begin
                        pend_sel_nxt = req_sel;
                        pend_tgt_nxt = req_tgt;
                    end
                end else begin
                    sel_o        = (req_sel > pend_sel) ? req_sel : pend_sel;
                    pend_sel_nxt = 2'd0;
                    pend_tgt_nxt = '0;
                    state_nxt    = FLUSH;
                    fcnt_nxt     = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                // Jump/branch requests here come from squashed instructions.
                if (trap_valid_i) begin
                    if (!hazard_stall_i) begin
                        sel_o    = 2'd3;
                        fcnt_nxt = FLUSH_LOAD;
                    end else begin
                        pend_sel_nxt = 2'd3;
                        pend_tgt_nxt = trap_vector_i;
                        state_nxt    = PEND;
                    end
                end else if (fcnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    fcnt_nxt = fcnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pend_sel       <= 2'd0;
            pend_tgt       <= '0;
            fcnt           <= 4'd0;
            redirect_cnt_o <= 16'd0;
        end else begin
            state    <= state_nxt;
            pend_sel <= pend_sel_nxt;
            pend_tgt <= pend_tgt_nxt;
            fcnt     <= fcnt_nxt;
            if (sel_o != 2'd0 && !hazard_stall_i && redirect_cnt_o != 16'hFFFF)
                redirect_cnt_o <= redirect_cnt_o + 16'd1;
        end
    end

    assign pc_stall_o = hazard_stall_i;
    assign flush_o    = (state == FLUSH);
    assign busy_o     = (state != IDLE);

    assign tgt1_o = (state == PEND && pend_sel == 2'd1) ? pend_tgt : jal_target_i;
    assign tgt2_o = (state == PEND && pend_sel == 2'd2) ? pend_tgt : br_target_i;
    assign tgt3_o = (state == PEND && pend_sel == 2'd3) ? pend_tgt : trap_vector_i;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl: each driven cycle pushes its
// hand-derived expectation, popped and compared at the following falling edge.
module tb_pc_redirect_ctrl;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          hazard_stall_i;
    logic          jal_valid_i, br_valid_i, br_taken_i, trap_valid_i;
    logic [AW-1:0] jal_target_i, br_target_i, trap_vector_i;
    logic [1:0]    sel_o;
    logic          pc_stall_o, flush_o, busy_o;
    logic [AW-1:0] tgt1_o, tgt2_o, tgt3_o;
    logic [15:0]   redirect_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          stall;
        logic [1:0]    sel;
        logic [AW-1:0] tgt;
        logic          flush;
        logic          busy;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb[$];

    pc_redirect_ctrl #(.ADDR_SIZE(AW), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .hazard_stall_i(hazard_stall_i),
        .jal_valid_i(jal_valid_i), .jal_target_i(jal_target_i),
        .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
        .sel_o(sel_o), .pc_stall_o(pc_stall_o),
        .tgt1_o(tgt1_o), .tgt2_o(tgt2_o), .tgt3_o(tgt3_o),
        .flush_o(flush_o), .busy_o(busy_o), .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        hazard_stall_i = 1'b0;
        jal_valid_i = 1'b0; br_valid_i = 1'b0; br_taken_i = 1'b0; trap_valid_i = 1'b0;
    endtask

    // Drive one cycle: st stall, j/b/t request bits with targets, then expectation.
    task automatic cyc(input logic st, input logic j, input logic [AW-1:0] jt,
                       input logic b, input logic [AW-1:0] bt,
                       input logic t, input logic [AW-1:0] tv,
                       input logic [1:0] esel, input logic [AW-1:0] etgt,
                       input logic efl, input logic ebz, input logic [15:0] ecnt);
        exp_t e;
        exp_t p;
        logic [AW-1:0] tsel;
        hazard_stall_i = st;
        jal_valid_i = j;  jal_target_i = jt;
        br_valid_i = b;   br_taken_i = b; br_target_i = bt;
        trap_valid_i = t; trap_vector_i = tv;
        e.stall = st; e.sel = esel; e.tgt = etgt; e.flush = efl; e.busy = ebz; e.cnt = ecnt;
        sb.push_back(e);
        @(negedge clk);
        p = sb.pop_front();
        chk("sel", 32'(sel_o), 32'(p.sel));
        chk("pc_stall", 32'(pc_stall_o), 32'(p.stall));
        chk("flush", 32'(flush_o), 32'(p.flush));
        chk("busy", 32'(busy_o), 32'(p.busy));
        chk("cnt", 32'(redirect_cnt_o), 32'(p.cnt));
        if (p.sel != 2'd0) begin
            tsel = (p.sel == 2'd1) ? tgt1_o : (p.sel == 2'd2) ? tgt2_o : tgt3_o;
            chk("tgt", 32'(tsel), 32'(p.tgt));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        jal_target_i = 20'h00123; br_target_i = 20'h00456; trap_vector_i = 20'h00789;
        #12;
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", 32'(redirect_cnt_o), 32'd0);
        chk("rst_tgt1", 32'(tgt1_o), 32'h00123);
        chk("rst_tgt2", 32'(tgt2_o), 32'h00456);
        chk("rst_tgt3", 32'(tgt3_o), 32'h00789);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Unstalled jump
        cyc(0, 1, 20'h00100, 0, 0, 0, 0, 2'd1, 20'h00100, 0, 0, 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd1);

        // All three at once: trap wins, others never applied
        cyc(0, 1, 20'h00111, 1, 20'h00222, 1, 20'h00040, 2'd3, 20'h00040, 0, 0, 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd2);

        // Branch during a 3-cycle stall, target held in pending register
        cyc(1, 0, 0, 1, 20'h00200, 0, 0, 2'd0, 0, 0, 0, 16'd2);
        cyc(1, 0, 0, 0, 20'h00999, 0, 0, 2'd0, 0, 0, 1, 16'd2);
        cyc(1, 0, 0, 0, 20'h00999, 0, 0, 2'd0, 0, 0, 1, 16'd2);
        cyc(0, 0, 0, 0, 20'h00999, 0, 0, 2'd2, 20'h00200, 0, 1, 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd3);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd3);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd3);

        // Pending branch: jump dropped, trap replaces it
        cyc(1, 0, 0, 1, 20'h00200, 0, 0, 2'd0, 0, 0, 0, 16'd3);
        cyc(1, 1, 20'h00300, 0, 0, 0, 0, 2'd0, 0, 0, 1, 16'd3);
        cyc(1, 0, 0, 0, 0, 1, 20'h00500, 2'd0, 0, 0, 1, 16'd3);
        cyc(0, 0, 0, 0, 0, 0, 20'h00777, 2'd3, 20'h00500, 0, 1, 16'd3);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd4);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd4);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd4);

        // Pending jump released together with a higher-priority branch
        cyc(1, 1, 20'h00310, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd4);
        cyc(0, 0, 0, 1, 20'h00250, 0, 0, 2'd2, 20'h00250, 0, 1, 16'd4);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd5);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd5);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd5);

        // In flush: jump ignored, trap applied and flush extended
        cyc(0, 1, 20'h00100, 0, 0, 0, 0, 2'd1, 20'h00100, 0, 0, 16'd5);
        cyc(0, 1, 20'h00111, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd6);
        cyc(0, 0, 0, 0, 0, 1, 20'h00060, 2'd3, 20'h00060, 1, 1, 16'd6);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd7);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 16'd7);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd7);

        // Reset while pending
        cyc(1, 1, 20'h00400, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd7);
        chk("pend_busy", 32'(busy_o), 32'd1);
        chk("pend_tgt1", 32'(tgt1_o), 32'h00400);
        jal_valid_i = 1'b0; jal_target_i = 20'h00ABC;
        reset = 1'b1;
        #1;
        chk("rstp_busy", 32'(busy_o), 32'd0);
        chk("rstp_flush", 32'(flush_o), 32'd0);
        chk("rstp_cnt", 32'(redirect_cnt_o), 32'd0);
        chk("rstp_tgt1", 32'(tgt1_o), 32'h00ABC);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16'd0);

        if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
